// File: rtl/pong_vga_renderer_if.sv
// Game-state / video bundle between the pong game logic and the VGA renderer.
// The game side drives coordinates and consumes the frame tick; the renderer does the reverse.
interface pong_vga_renderer_if #(
  parameter int BIT_WIDTH = 10
);
  logic [BIT_WIDTH:0] ball_x;
  logic [BIT_WIDTH:0] ball_y;
  logic [BIT_WIDTH:0] p1y;
  logic [BIT_WIDTH:0] p2y;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [11:0]        rgb;
  logic               frame_tick;

  modport master (
    output ball_x, ball_y, p1y, p2y,
    input  hsync, vsync, de, rgb, frame_tick
  );

  modport slave (
    input  ball_x, ball_y, p1y, p2y,
    output hsync, vsync, de, rgb, frame_tick
  );
endinterface

// File: rtl/pong_vga_renderer.sv
// VGA timing generator and pong scene renderer: shadows game coordinates at vblank
// and emits registered sync/de/rgb one pixel-enable cycle after the counters.
module pong_vga_renderer #(
  parameter int BIT_WIDTH     = 10,
  parameter int BALL_RADIUS   = 4,
  parameter int PADDLE_RADIUS = 8,
  parameter int PADDLE_HALF_W = 2,
  parameter int P1X           = 50,
  parameter int P2X           = 590,
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_en,
  pong_vga_renderer_if.slave  vif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int TW      = $clog2(H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL);
  localparam int CW      = BIT_WIDTH + 2;

  typedef logic [CW-1:0]    ext_t;
  typedef logic [BIT_WIDTH:0] coord_t;

  logic [TW-1:0] h_cnt, v_cnt;
  coord_t        sbx, sby, sp1, sp2;
  logic          end_line, load_frame;

  logic          hsync_q, vsync_q, de_q;
  logic [11:0]   rgb_q;

  logic          visible, ball_hit, p1_hit, p2_hit, net_hit;
  logic          hsync_nxt, vsync_nxt;
  logic [11:0]   rgb_nxt;
  ext_t          px, py;

  // Radius is added to both sides so coordinates near 0 never underflow.
  function automatic logic near(input ext_t a, input ext_t c, input ext_t r);
    return (a + r >= c) && (a <= c + r);
  endfunction

  assign end_line   = (h_cnt == TW'(H_TOTAL - 1));
  assign load_frame = end_line && (v_cnt == TW'(V_VISIBLE - 1));

  assign px = ext_t'(h_cnt);
  assign py = ext_t'(v_cnt);

  always_comb begin
    visible   = (h_cnt < TW'(H_VISIBLE)) && (v_cnt < TW'(V_VISIBLE));
    ball_hit  = near(px, ext_t'(sbx), ext_t'(BALL_RADIUS)) &&
                near(py, ext_t'(sby), ext_t'(BALL_RADIUS));
    p1_hit    = near(px, ext_t'(P1X), ext_t'(PADDLE_HALF_W)) &&
                near(py, ext_t'(sp1), ext_t'(PADDLE_RADIUS));
    p2_hit    = near(px, ext_t'(P2X), ext_t'(PADDLE_HALF_W)) &&
                near(py, ext_t'(sp2), ext_t'(PADDLE_RADIUS));
    net_hit   = ((h_cnt == TW'(H_VISIBLE / 2 - 1)) || (h_cnt == TW'(H_VISIBLE / 2))) &&
                !v_cnt[3];
    hsync_nxt = !((h_cnt >= TW'(H_VISIBLE + H_FRONT)) &&
                  (h_cnt <  TW'(H_VISIBLE + H_FRONT + H_SYNC)));
    vsync_nxt = !((v_cnt >= TW'(V_VISIBLE + V_FRONT)) &&
                  (v_cnt <  TW'(V_VISIBLE + V_FRONT + V_SYNC)));
    if (!visible)      rgb_nxt = 12'h000;
    else if (ball_hit) rgb_nxt = 12'hFFF;
    else if (p1_hit)   rgb_nxt = 12'hF00;
    else if (p2_hit)   rgb_nxt = 12'h00F;
    else if (net_hit)  rgb_nxt = 12'h888;
    else               rgb_nxt = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      sbx     <= coord_t'(H_VISIBLE / 2);
      sby     <= coord_t'(V_VISIBLE / 2);
      sp1     <= coord_t'(V_VISIBLE / 2);
      sp2     <= coord_t'(V_VISIBLE / 2);
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else if (pix_en) begin
      h_cnt <= end_line ? '0 : h_cnt + TW'(1);
      if (end_line)
        v_cnt <= (v_cnt == TW'(V_TOTAL - 1)) ? '0 : v_cnt + TW'(1);
      if (load_frame) begin
        sbx <= vif.ball_x;
        sby <= vif.ball_y;
        sp1 <= vif.p1y;
        sp2 <= vif.p2y;
      end
      hsync_q <= hsync_nxt;
      vsync_q <= vsync_nxt;
      de_q    <= visible;
      rgb_q   <= rgb_nxt;
    end
  end

  // Tick marks the cycle whose closing edge loads the shadows and enters vblank.
  assign vif.frame_tick = pix_en && !rst && load_frame;
  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.de         = de_q;
  assign vif.rgb        = rgb_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer on a reduced 64x32 raster: cycle scoreboard of all
// video outputs plus table-driven frame-buffer probes and multi-frame sequences.
module tb_pong_vga_renderer;

  localparam int BW = 10;
  localparam int HV = 64, HF = 2, HS = 6, HB = 4;
  localparam int VV = 32, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int BR = 4, PR = 8, HW = 2, P1 = 10, P2 = 54;

  typedef logic [BW:0] coord_t;

  typedef struct {
    int          x;
    int          y;
    int          kind;  // 0 hold, 1 pixel, 2 reset
    logic [14:0] out;
  } exp_t;

  typedef struct {
    int          bx;
    int          by;
    int          p1;
    int          p2;
    int          px;
    int          py;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic toggle_mode = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  logic [11:0] fb [VV][HV];

  int m_h = 0, m_v = 0;
  int s_bx, s_by, s_p1, s_p2;
  logic [14:0] exp_out = '0;
  int clk_cnt = 0, pe_cnt = 0, last_clk = 0, last_pe = 0, last_period_clk = 0;
  int tick_count = 0;
  logic have_prev = 1'b0;
  int hs_low = 0, de_cnt = 0, vs_low = 0;

  vec_t tbl[23];

  always #5 clk = ~clk;

  pong_vga_renderer_if #(.BIT_WIDTH(BW)) vif ();

  pong_vga_renderer #(
    .BIT_WIDTH(BW), .BALL_RADIUS(BR), .PADDLE_RADIUS(PR), .PADDLE_HALF_W(HW),
    .P1X(P1), .P2X(P2),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vif(vif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [14:0] ref_out(input int x, input int y, input int bx,
                                          input int by, input int p1, input int p2);
    logic hs, vs, de;
    logic [11:0] c;
    hs = !(x >= HV + HF && x < HV + HF + HS);
    vs = !(y >= VV + VF && y < VV + VF + VS);
    de = (x < HV) && (y < VV);
    if (!de)                                          c = 12'h000;
    else if (absd(x, bx) <= BR && absd(y, by) <= BR)  c = 12'hFFF;
    else if (absd(x, P1) <= HW && absd(y, p1) <= PR)  c = 12'hF00;
    else if (absd(x, P2) <= HW && absd(y, p2) <= PR)  c = 12'h00F;
    else if ((x == HV / 2 - 1 || x == HV / 2) && ((y / 8) % 2 == 0)) c = 12'h888;
    else                                              c = 12'h000;
    return {hs, vs, de, c};
  endfunction

  // Output checks just after each rising edge, model step on each falling edge.
  always begin : monitor
    exp_t e;
    logic exp_tick;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("outputs(h=%0d,v=%0d)", e.x, e.y),
            {17'd0, vif.hsync, vif.vsync, vif.de, vif.rgb}, {17'd0, e.out});
      if (e.kind == 2) begin
        hs_low = 0; de_cnt = 0; vs_low = 0;
      end else if (e.kind == 1) begin
        if (e.x < HV && e.y < VV) fb[e.y][e.x] = vif.rgb;
        hs_low += int'(!vif.hsync);
        de_cnt += int'(vif.de);
        vs_low += int'(!vif.vsync);
        if (e.x == HT - 1) begin
          check($sformatf("hsync_low_line%0d", e.y), hs_low, HS);
          check($sformatf("de_count_line%0d", e.y), de_cnt, (e.y < VV) ? HV : 0);
          hs_low = 0;
          de_cnt = 0;
          if (e.y == VT - 1) begin
            check("vsync_low_frame", vs_low, VS * HT);
            vs_low = 0;
          end
        end
      end
    end
    @(negedge clk);
    clk_cnt++;
    exp_tick = !rst && pix_en && (m_h == HT - 1) && (m_v == VV - 1);
    check("frame_tick", {31'd0, vif.frame_tick}, {31'd0, exp_tick});
    if (rst) have_prev = 1'b0;
    else if (pix_en) pe_cnt++;
    if (vif.frame_tick === 1'b1) begin
      tick_count++;
      if (have_prev) check("tick_period_pix_en", pe_cnt - last_pe, FRAME);
      last_period_clk = clk_cnt - last_clk;
      last_pe   = pe_cnt;
      last_clk  = clk_cnt;
      have_prev = 1'b1;
    end
    e.x = m_h;
    e.y = m_v;
    if (rst) begin
      m_h = 0; m_v = 0;
      s_bx = HV / 2; s_by = VV / 2; s_p1 = VV / 2; s_p2 = VV / 2;
      exp_out = {1'b1, 1'b1, 1'b0, 12'h000};
      e.kind = 2;
    end else if (pix_en) begin
      exp_out = ref_out(m_h, m_v, s_bx, s_by, s_p1, s_p2);
      e.kind = 1;
      if (exp_tick) begin
        s_bx = int'(vif.ball_x); s_by = int'(vif.ball_y);
        s_p1 = int'(vif.p1y);    s_p2 = int'(vif.p2y);
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end else begin
      e.kind = 0;
    end
    e.out = exp_out;
    sb.push_back(e);
  end

  initial begin : pix_en_drv
    pix_en = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      pix_en = toggle_mode ? ~pix_en : 1'b1;
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_count + n;
    for (int c = 0; c < (n + 1) * 2 * FRAME && tick_count < target; c++) @(negedge clk);
    check("frame_tick_wait", {31'd0, tick_count >= target}, 32'd1);
  endtask

  task automatic wait_row(input int v);
    for (int c = 0; c < 2 * FRAME && m_v != v; c++) @(negedge clk);
    check("row_wait", m_v, v);
  endtask

  task automatic set_state(input int bx, input int by, input int a, input int b);
    @(posedge clk);
    #2;
    vif.ball_x = coord_t'(bx);
    vif.ball_y = coord_t'(by);
    vif.p1y    = coord_t'(a);
    vif.p2y    = coord_t'(b);
  endtask

  initial begin : stim
    tbl[0]  = '{20, 20, 26, 26, 16, 20, 12'hFFF};
    tbl[1]  = '{20, 20, 26, 26, 24, 20, 12'hFFF};
    tbl[2]  = '{20, 20, 26, 26, 20, 16, 12'hFFF};
    tbl[3]  = '{20, 20, 26, 26, 24, 24, 12'hFFF};
    tbl[4]  = '{20, 20, 26, 26, 15, 20, 12'h000};
    tbl[5]  = '{20, 20, 26, 26, 25, 20, 12'h000};
    tbl[6]  = '{ 2,  2, 26, 26,  0,  0, 12'hFFF};
    tbl[7]  = '{ 2,  2, 26, 26,  6,  6, 12'hFFF};
    tbl[8]  = '{ 2,  2, 26, 26,  0,  6, 12'hFFF};
    tbl[9]  = '{ 2,  2, 26, 26,  7,  3, 12'h000};
    tbl[10] = '{ 2,  2, 26, 26, 60,  2, 12'h000};
    tbl[11] = '{ 2,  2, 26, 26, 63,  2, 12'h000};
    tbl[12] = '{10, 10, 10, 26, 10, 10, 12'hFFF};
    tbl[13] = '{10, 10, 10, 26, 12, 14, 12'hFFF};
    tbl[14] = '{10, 10, 10, 26, 10, 17, 12'hF00};
    tbl[15] = '{10, 10, 10, 26,  8,  2, 12'hF00};
    tbl[16] = '{10, 10, 10, 26, 13, 10, 12'hFFF};
    tbl[17] = '{10, 10, 10, 26, 10, 19, 12'h000};
    tbl[18] = '{10, 10, 10, 26, 54, 26, 12'h00F};
    tbl[19] = '{10, 10, 10, 26, 57, 26, 12'h000};
    tbl[20] = '{10, 10, 10, 26, 31,  0, 12'h888};
    tbl[21] = '{10, 10, 10, 26, 32,  8, 12'h000};
    tbl[22] = '{10, 10, 10, 26, 32, 16, 12'h888};

    rst = 1'b1;
    vif.ball_x = coord_t'(HV / 2);
    vif.ball_y = coord_t'(VV / 2);
    vif.p1y    = coord_t'(VV / 2);
    vif.p2y    = coord_t'(VV / 2);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // First frame after reset renders the reset-time shadows.
    wait_ticks(1);
    check("reset_ball_centre", fb[16][32], 12'hFFF);
    check("reset_ball_corner_lo", fb[12][28], 12'hFFF);
    check("reset_ball_corner_hi", fb[20][36], 12'hFFF);
    check("reset_ball_left_out", fb[16][27], 12'h000);
    check("reset_ball_right_out", fb[16][37], 12'h000);
    check("reset_paddle1", fb[16][10], 12'hF00);
    check("reset_paddle2", fb[16][54], 12'h00F);

    for (int i = 0; i < 23; i++) begin
      if (i == 0 || tbl[i].bx != tbl[i-1].bx || tbl[i].by != tbl[i-1].by ||
          tbl[i].p1 != tbl[i-1].p1 || tbl[i].p2 != tbl[i-1].p2) begin
        set_state(tbl[i].bx, tbl[i].by, tbl[i].p1, tbl[i].p2);
        wait_ticks(2);
      end
      check($sformatf("vec%0d(%0d,%0d)", i, tbl[i].px, tbl[i].py),
            fb[tbl[i].py][tbl[i].px], tbl[i].rgb);
    end

    // Half-rate pixel enable: tick period doubles, picture unchanged.
    toggle_mode = 1'b1;
    wait_ticks(2);
    check("toggle_tick_period_clk", last_period_clk, 2 * FRAME);
    check("toggle_overlap", fb[10][10], 12'hFFF);
    check("toggle_paddle1", fb[17][10], 12'hF00);
    check("toggle_paddle2", fb[26][54], 12'h00F);
    check("toggle_net", fb[0][31], 12'h888);
    toggle_mode = 1'b0;

    // Coordinate change mid-frame must wait for the next vblank load.
    set_state(20, 20, 26, 26);
    wait_ticks(1);
    wait_row(10);
    @(posedge clk);
    #2;
    vif.ball_x = coord_t'(40);
    wait_ticks(1);
    check("iso_old_pos_drawn", fb[20][20], 12'hFFF);
    check("iso_new_pos_blank", fb[20][40], 12'h000);
    wait_ticks(1);
    check("iso_new_pos_drawn", fb[20][40], 12'hFFF);
    check("iso_old_pos_blank", fb[20][20], 12'h000);

    // Reset in the middle of a frame restarts timing and shadows.
    wait_row(20);
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_ticks(1);
    check("midreset_ball_reset_pos", fb[16][32], 12'hFFF);
    check("midreset_old_ball_gone", fb[20][40], 12'h000);
    wait_ticks(1);
    check("midreset_reload", fb[20][40], 12'hFFF);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation still running, required completion before 150000 clk");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pong_vga_renderer.md
Name: pong_vga_renderer

Overview:
- Display-side consumer of the game-state coordinates produced by the pong top level: ball_x, ball_y, p1y and p2y.
- Generates 640x480@60 VGA timing and draws ball, paddles, centre net and background as 12-bit RGB.
- Samples game coordinates once per frame, at the start of vertical blanking, so each displayed frame is tear-free.
- Emits a per-frame tick that the game logic uses to advance ball and paddle state.

Parameters:
- BIT_WIDTH, 10, coordinate ports are BIT_WIDTH+1 bits wide ([BIT_WIDTH:0]).
- BALL_RADIUS, 4, ball half-size in pixels; the ball is drawn as a square.
- PADDLE_RADIUS, 8, paddle half-height in pixels.
- PADDLE_HALF_W, 2, paddle half-width in pixels.
- P1X, 50, fixed paddle-1 centre x.
- P2X, 590, fixed paddle-2 centre x.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- pix_en  input  1  pixel-rate clock enable (25 MHz strobe; tie high for a 25 MHz clk)
- ball_x  input  BIT_WIDTH+1  ball centre x
- ball_y  input  BIT_WIDTH+1  ball centre y
- p1y  input  BIT_WIDTH+1  paddle-1 centre y
- p2y  input  BIT_WIDTH+1  paddle-2 centre y
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- de  output  1  display enable, high in the visible region
- rgb  output  12  pixel colour, 4:4:4 (R[11:8] G[7:4] B[3:0])
- frame_tick  output  1  one-clk pulse at the start of vertical blanking

Behaviour:
- All state advances only on clk edges where pix_en=1. When pix_en=0, all registers hold and frame_tick=0.
- h_cnt counts 0..799 and wraps to 0. v_cnt increments when h_cnt wraps, counts 0..524 and wraps to 0.
- Horizontal timing: visible 0..639; hsync low for h_cnt 656..751.
- Vertical timing: visible 0..479; vsync low for v_cnt 490..491.
- de is high when h_cnt<640 and v_cnt<480.
- Coordinate shadow registers (ball_x, ball_y, p1y, p2y):
  - Loaded on the pix_en cycle where the counters advance to (h=0, v=480).
  - Rendering uses only the shadow values.
  - Input changes at any other time have no effect until the next load.
- frame_tick: asserted for exactly that same clk cycle, once per 420000 pix_en cycles.
- Draw tests use unsigned arithmetic at BIT_WIDTH+2 bits, with no subtraction of radii from coordinates. This prevents underflow and wrap-around at screen edges.
  - Ball hit: (x+BALL_RADIUS >= sbx) and (x <= sbx+BALL_RADIUS), and the same form in y.
  - Paddle hit: the same form using PADDLE_HALF_W about P1X or P2X, and PADDLE_RADIUS about the paddle's y.
  - Net: x in 319..320 and v_cnt[3]=0.
- Colour priority, highest first:
  - outside visible region: 000
  - ball: FFF
  - paddle 1: F00
  - paddle 2: 00F
  - net: 888
  - background: 000
- Output pipeline:
  - hsync, vsync, de and rgb are registered from the same counter values, so all outputs stay mutually aligned.
  - Latency is 1 pix_en cycle: the outputs for counter (h, v) appear one pix_en cycle after the counters hold (h, v).
- Reset (synchronous, rst=1 at a clk edge, independent of pix_en):
  - h_cnt=0, v_cnt=0.
  - Shadows: ball=(320,240), p1y=240, p2y=240.
  - Outputs: hsync=1, vsync=1, de=0, rgb=000, frame_tick=0.
- Reset mid-frame: timing restarts at (0,0) on the next pix_en cycle. No partial frame_tick.

Test Plan:
- Reset check: hold rst for 3 clk, then release with pix_en=1.
  - Required: during reset, hsync=1, vsync=1, de=0, rgb=000, frame_tick=0.
  - Required: the first output pixel after release is (0,0) with the shadow ball at (320,240), so pixel (316..324, 236..244)=FFF.
- Timing: free-run 2 frames with pix_en=1.
  - hsync low for exactly 96 consecutive pix_en cycles per 800-cycle line.
  - vsync low for 1600 cycles per frame.
  - de high for 640 cycles per line.
  - frame_tick period is 420000 cycles.
- Ball draw: ball=(100,100) loaded at vblank.
  - Next frame: rgb=FFF at x,y in 96..104.
  - Next frame: rgb=000 at (95,100) and at (105,100).
- Edge case: ball=(2,2).
  - Pixels x=0..6 on y=0..6 are FFF.
  - Pixels x=636..639 are not FFF (no wrap).
- Shadow isolation: change ball_x from 100 to 300 at v_cnt=200.
  - The current frame still draws the ball at x=100.
  - The ball moves to x=300 only after the next frame_tick.
- Priority and enable: ball=(50,50) with p1y=50.
  - Overlap pixels are FFF; paddle-only pixels are F00.
  - With pix_en toggling every other clk, the frame_tick period becomes 840000 clk and the outputs are unchanged.
